// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-serial UART transmitter between N_REQ sources.
// Grants whole messages, caps the message length and enforces an idle gap between messages.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int GAP_CYCLES  = 1000,
    parameter int MAX_MSG_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     hold,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic                     grant_active,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     err_overlong
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [7:0]       MAX_LEN  = 8'(MAX_MSG_LEN);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

    state_t           state, state_next;
    logic [ID_W-1:0]  rr_ptr, winner, scan_idx;
    logic             any_req, accept, sel_valid, sel_last, drain_done, overlong;
    logic [7:0]       sel_data, byte_cnt;
    logic [GAP_W-1:0] gap_cnt;

    // Only the granted requester's lane is ever looked at.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // First requesting source at or after rr_ptr, wrapping around.
    always_comb begin
        winner   = rr_ptr;
        any_req  = 1'b0;
        scan_idx = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!any_req && req_valid[scan_idx]) begin
                winner  = scan_idx;
                any_req = 1'b1;
            end
        end
    end

    assign accept       = (state == XFER) && sel_valid && !hold && (!tx_valid || tx_ready);
    assign drain_done   = !tx_valid || tx_ready;
    assign overlong     = (byte_cnt + 8'd1) == MAX_LEN;
    assign grant_active = (state == XFER) || (state == DRAIN);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept && grant_id == ID_W'(i)) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!hold && any_req) state_next = XFER;
            XFER:    if (accept && (sel_last || overlong)) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A byte accepted in the same cycle as a handshake keeps tx_valid high without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            grant_id     <= '0;
            rr_ptr       <= '0;
            byte_cnt     <= 8'h00;
            gap_cnt      <= '0;
            err_overlong <= 1'b0;
        end else begin
            err_overlong <= 1'b0;
            if (state == IDLE && state_next == XFER) begin
                grant_id <= winner;
                byte_cnt <= 8'h00;
            end
            if (accept) begin
                tx_valid <= 1'b1;
                tx_data  <= sel_data;
                byte_cnt <= byte_cnt + 8'd1;
                if (!sel_last && overlong) begin
                    err_overlong <= 1'b1;
                end
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
            if (state == DRAIN && drain_done) begin
                rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter checked every cycle against a message-level model,
// with a few directed sequences whose expectations are written out by hand.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N      = 4;
    localparam int IW     = $clog2(N);
    localparam int GAP    = 4;
    localparam int MAXLEN = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           hold, tx_valid, tx_ready, grant_active, err_overlong;
    logic [7:0]     tx_data;
    logic [IW-1:0]  grant_id;

    uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .MAX_MSG_LEN(MAXLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .hold(hold),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant_active(grant_active), .grant_id(grant_id), .err_overlong(err_overlong)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatch = 0;

    // Per-source byte FIFOs holding {last, data}.
    logic [8:0] src_mem[N][256];
    int         src_head[N] = '{default: 0};
    int         src_tail[N] = '{default: 0};
    bit         random_mode = 1'b0;
    bit         force_hold  = 1'b0;

    // Reference model: who owns the transmitter, how far into the message, gap left, output slot.
    bit            m_busy, m_drain, m_err, m_out_valid;
    int            m_count, m_gap_left;
    logic [IW-1:0] m_owner, m_rr;
    logic [7:0]    m_out_byte;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushByte(input int r, input logic [7:0] b, input bit last);
        src_mem[r][8'(src_tail[r])] = {last, b};
        src_tail[r]++;
    endtask

    task automatic applyStimulus();
        logic [N-1:0]   nv, nl;
        logic [8*N-1:0] nd;
        nv = '0;
        nl = '0;
        nd = '0;
        if (random_mode && $urandom_range(0, 99) < 12) begin
            int r   = $urandom_range(0, N - 1);
            int len = $urandom_range(1, 7);
            if (src_tail[r] - src_head[r] < 200) begin
                for (int k = 0; k < len; k++) pushByte(r, 8'($urandom), k == len - 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            logic [8:0] ent;
            bit present = (src_tail[i] != src_head[i]);
            bit gate    = random_mode ? ($urandom_range(0, 99) < 85) : 1'b1;
            ent = (present && gate) ? src_mem[i][8'(src_head[i])] : 9'($urandom);
            nv  = nv | (N'(present && gate) << i);
            nl  = nl | (N'(ent[8]) << i);
            nd  = nd | ((8*N)'(ent[7:0]) << (8*i));
        end
        req_valid = nv;
        req_last  = nl;
        req_data  = nd;
        tx_ready  = random_mode ? ($urandom_range(0, 99) < 70) : 1'b1;
        hold      = random_mode ? ($urandom_range(0, 99) < 5) : force_hold;
    endtask

    always @(posedge clk) begin
        #1;
        applyStimulus();
    end

    always @(posedge clk or posedge rst) begin : model
        if (rst) begin
            m_busy = 0; m_drain = 0; m_err = 0; m_out_valid = 0;
            m_count = 0; m_gap_left = 0; m_owner = '0; m_rr = '0; m_out_byte = 8'h00;
            for (int i = 0; i < N; i++) src_head[i] = src_tail[i];
        end else begin
            bit acc, hs;
            acc = m_busy && req_valid[m_owner] && !hold && (!m_out_valid || tx_ready);
            hs  = m_out_valid && tx_ready;
            m_err = 0;
            if (m_gap_left > 0) begin
                m_gap_left--;
            end else if (m_drain) begin
                if (!m_out_valid || tx_ready) begin
                    m_drain    = 0;
                    m_rr       = IW'((int'(m_owner) + 1) % N);
                    m_gap_left = GAP;
                end
            end else if (m_busy) begin
                if (acc) begin
                    m_count++;
                    if (req_last[m_owner]) begin
                        m_busy = 0; m_drain = 1;
                    end else if (m_count == MAXLEN) begin
                        m_busy = 0; m_drain = 1; m_err = 1;
                    end
                end
            end else if (!hold && req_valid != '0) begin
                for (int k = 0; k < N; k++) begin
                    logic [IW-1:0] cand;
                    cand = IW'((int'(m_rr) + k) % N);
                    if (!m_busy && req_valid[cand]) begin
                        m_owner = cand; m_busy = 1; m_count = 0;
                    end
                end
            end
            if (hs) m_out_valid = 0;
            if (acc) begin
                m_out_valid = 1;
                m_out_byte  = req_data[{m_owner, 3'b000} +: 8];
                src_head[m_owner]++;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] exp_ready;
        exp_ready = '0;
        if (m_busy && req_valid[m_owner] && !hold && (!m_out_valid || tx_ready)) exp_ready[m_owner] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("tx_valid", 32'(tx_valid), 32'(m_out_valid));
        if (m_out_valid) checkOutput("tx_data", 32'(tx_data), 32'(m_out_byte));
        checkOutput("grant_active", 32'(grant_active), 32'(m_busy || m_drain));
        checkOutput("grant_id", 32'(grant_id), 32'(m_owner));
        checkOutput("err_overlong", 32'(err_overlong), 32'(m_err));
    end

    task automatic waitIdle(input string name);
        int budget = 0;
        while (budget < 500 && (m_busy || m_drain || m_gap_left != 0 || m_out_valid ||
               src_head[0] != src_tail[0] || src_head[1] != src_tail[1] ||
               src_head[2] != src_tail[2] || src_head[3] != src_tail[3])) begin
            @(negedge clk);
            budget++;
        end
        checkOutput(name, 32'(budget < 500), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d compared so far", n_compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] hoge[4];
        int errs, hs, w;
        hoge = '{8'h48, 8'h4F, 8'h47, 8'h45};
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; hold = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("reset_grant_active", 32'(grant_active), 32'd0);
        checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
        @(negedge clk);

        // "HOGE" from requester 2 with the serializer always ready.
        for (int k = 0; k < 4; k++) pushByte(2, hoge[k], k == 3);
        @(negedge clk);
        checkOutput("hoge_c0_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        checkOutput("hoge_c1_grant_id", 32'(grant_id), 32'd2);
        checkOutput("hoge_c1_ready", 32'(req_ready), 32'b0100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("hoge_tx_valid", 32'(tx_valid), 32'd1);
            checkOutput("hoge_tx_data", 32'(tx_data), 32'(hoge[k]));
        end
        checkOutput("hoge_c5_drain_active", 32'(grant_active), 32'd1);
        @(negedge clk);
        checkOutput("hoge_c6_gap_active", 32'(grant_active), 32'd0);
        checkOutput("hoge_c6_tx_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        pushByte(3, 8'h31, 1'b0); pushByte(3, 8'h32, 1'b1); pushByte(2, 8'h21, 1'b1);
        @(negedge clk);
        checkOutput("gap_ignores_requests", 32'(grant_active), 32'd0);
        @(negedge clk);
        checkOutput("idle_after_gap", 32'(grant_active), 32'd0);
        @(negedge clk);
        checkOutput("rr_next_after_2", 32'(grant_id), 32'd3);
        waitIdle("drain_after_hoge");

        // Requester 1 sends 7 bytes with a 5-byte cap; the tail goes out in a second grant.
        for (int k = 0; k < 7; k++) pushByte(1, 8'hA0 + 8'(k), k == 6);
        errs = 0; hs = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (err_overlong) errs++;
            if (tx_valid && tx_ready) hs++;
        end
        checkOutput("overlong_first_grant_bytes", 32'(hs), 32'd5);
        checkOutput("overlong_err_pulses", 32'(errs), 32'd1);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (err_overlong) errs++;
            if (tx_valid && tx_ready) hs++;
        end
        checkOutput("overlong_total_bytes", 32'(hs), 32'd7);
        checkOutput("overlong_err_total", 32'(errs), 32'd1);
        waitIdle("drain_after_overlong");

        // hold in IDLE blocks the grant until it is released.
        force_hold = 1'b1;
        pushByte(0, 8'h01, 1'b0); pushByte(0, 8'h02, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("hold_idle_no_grant", 32'(grant_active), 32'd0);
        end
        force_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_release_grant", 32'(grant_active), 32'd1);
        checkOutput("hold_release_grant_id", 32'(grant_id), 32'd0);
        waitIdle("drain_after_hold_idle");

        // hold after byte 2 of 4 from requester 3.
        for (int k = 0; k < 4; k++) pushByte(3, 8'hC0 + 8'(k), k == 3);
        repeat (3) @(negedge clk);
        force_hold = 1'b1;
        @(negedge clk);
        checkOutput("hold_mid_ready", 32'(req_ready), 32'd0);
        checkOutput("hold_mid_tx_data", 32'(tx_data), 32'hC1);
        @(negedge clk);
        checkOutput("hold_mid_tx_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        checkOutput("hold_mid_grant_kept", 32'(grant_active), 32'd1);
        force_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_resume_b3", 32'(tx_data), 32'hC2);
        @(negedge clk);
        checkOutput("hold_resume_b4", 32'(tx_data), 32'hC3);
        waitIdle("drain_after_hold_mid");

        // Randomized traffic checked by the model.
        random_mode = 1'b1;
        repeat (3000) @(negedge clk);

        // Asynchronous reset while a byte is in flight.
        w = 0;
        while (!(tx_valid && grant_active) && w < 500) begin
            @(negedge clk);
            w++;
        end
        checkOutput("reset_setup_found", 32'(w < 500), 32'd1);
        random_mode = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("async_reset_grant_active", 32'(grant_active), 32'd0);
        checkOutput("async_reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pushByte(3, 8'h77, 1'b1); pushByte(0, 8'h66, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_restart_from_0", 32'(grant_id), 32'd0);
        waitIdle("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-serial UART transmitter between N_REQ message sources. Example sources: status reporter, switch echo, debug dump.
- Grants the transmitter round-robin, one whole message at a time. Enforces an inter-message idle gap and a maximum message length.
- Sits between the requesters and the UART TX serializer, on the 100 MHz system clock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 1000, idle clk cycles after a message's last byte is handed off (0 allowed).
- MAX_MSG_LEN, 64, bytes allowed per grant before forced release (1..255).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a byte.
- req_data  in  8*N_REQ  byte of requester i, in bits [8i+7:8i].
- req_last  in  N_REQ  the byte is the last of its message.
- req_ready  out  N_REQ  byte of requester i accepted this cycle (combinational).
- hold  in  1  flow pause (switch or CTS); blocks new grants and byte acceptance.
- tx_valid  out  1  byte available to the serializer (registered).
- tx_data  out  8  byte to the serializer (registered).
- tx_ready  in  1  serializer accepts the byte when tx_valid && tx_ready.
- grant_active  out  1  a message is in progress (states XFER/DRAIN).
- grant_id  out  clog2(N_REQ)  current or last granted requester.
- err_overlong  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, immediate): state=IDLE; tx_valid=0, tx_data=0; grant_id=0; rr_ptr=0; grant_active=0; err_overlong=0; byte and gap counters=0. A byte in flight is dropped; the serializer must also be reset.
- States: IDLE, XFER, DRAIN, GAP.
- IDLE:
  - Requires !hold and any req_valid.
  - Winner = first set req_valid scanning from rr_ptr upward, with wrap-around.
  - Next cycle: grant_id=winner, state=XFER, byte_cnt=0.
  - req_ready is 0 in IDLE.
- XFER acceptance: req_ready[g] = (i==grant_id) && req_valid[g] && !hold && (!tx_valid || tx_ready).
- On acceptance:
  - tx_data<=req_data[g], tx_valid<=1, byte_cnt+1.
  - If req_last: state=DRAIN.
  - Else if byte_cnt+1==MAX_MSG_LEN: state=DRAIN and err_overlong pulses the next cycle. The requester's remaining bytes wait for a later grant.
- tx_valid handshake:
  - Once tx_valid=1, tx_data is stable until tx_valid && tx_ready.
  - Accepting a new byte in the same cycle as a handshake keeps tx_valid=1 with no bubble.
  - Handshake with no new byte: tx_valid<=0.
  - hold never drops an asserted tx_valid.
- Latency: req_valid rises at cycle 0 in IDLE → grant at cycle 1, first byte accepted at cycle 1, tx_valid=1 at cycle 2. Throughput is 1 byte/cycle when tx_ready is held high.
- XFER with req_valid[g]=0: remain in XFER and keep the grant. No timeout; only MAX_MSG_LEN releases.
- DRAIN: wait for the handshake of the final byte (tx_valid && tx_ready), or tx_valid already 0. Then:
  - rr_ptr<=(grant_id+1) mod N_REQ.
  - GAP_CYCLES>0: state=GAP, gap_cnt=0.
  - GAP_CYCLES=0: state=IDLE.
- GAP: gap_cnt increments each cycle; at gap_cnt==GAP_CYCLES-1 go to IDLE. Requests are ignored in GAP.
- grant_active=1 in XFER and DRAIN only. grant_id holds its value outside grants.
- Simultaneous requests in IDLE: exactly one grant. A non-granted requester's req_ready stays 0 and its data is never sampled.
- hold asserted mid-message: acceptance stops; the grant is kept; resumes on deassert.

Test Plan:
- Single source, N_REQ=4, GAP_CYCLES=4: req 2 sends "HOGE" (0x48,0x4F,0x47,0x45, last on 0x45), tx_ready=1 → tx_data sequence 48,4F,47,45 on consecutive cycles from cycle 2. grant_id=2. Then 4 GAP cycles, then IDLE. rr_ptr=3.
- Round-robin: all 4 requesters hold 2-byte messages continuously → grant order 0,1,2,3,0. Each message contiguous on tx_data; never interleaved.
- Backpressure: tx_ready toggles 1,0,0,1… → tx_data stable while tx_valid && !tx_ready. No byte lost or duplicated; req_ready=0 while stalled.
- Overlong: MAX_MSG_LEN=3, requester 1 sends 5 bytes with last only on byte 5 → 3 bytes sent, err_overlong single pulse. After the gap, requester 1 is regranted only after the other requesters' turns; bytes 4–5 go out.
- hold: assert hold after byte 2 of 4 → acceptance stops, tx_valid held until handshake, grant kept. Deassert → bytes 3–4 follow. hold in IDLE with req_valid=1 → no grant.
- Async reset mid-XFER with tx_valid=1 → tx_valid, grant_active, req_ready go to 0 without waiting for a clk edge. After release, arbitration restarts from requester 0.
